// File: rtl/mem_wb_stage_if.sv
// EX/MEM -> MEM/WB bundle: EX/MEM latch outputs in, MEM/WB latch and branch outputs back.
// Combinational signals only; no latency or backpressure of its own.
interface mem_wb_stage_if #(
   parameter int len_data    = 32,
   parameter int num_bits    = 5,
   parameter int len_mem_bus = 9,
   parameter int len_wb_bus  = 2
) ();
   logic [len_data-1:0]    in_alu;
   logic [len_data-1:0]    in_reg2;
   logic [num_bits-1:0]    in_write_reg;
   logic [len_data-1:0]    in_pc_branch;
   logic                   in_zero_flag;
   logic [len_mem_bus-1:0] memory_bus;
   logic [len_wb_bus-1:0]  writeBack_bus;
   logic                   in_halt_flag;

   logic                   out_pc_src;
   logic [len_data-1:0]    out_pc_branch;
   logic [len_data-1:0]    out_read_data;
   logic [len_data-1:0]    out_alu;
   logic [num_bits-1:0]    out_write_reg;
   logic [len_wb_bus-1:0]  writeBack_bus_out;
   logic                   out_halt_flag;
   logic                   out_misaligned;

   modport master (
      output in_alu, in_reg2, in_write_reg, in_pc_branch, in_zero_flag,
             memory_bus, writeBack_bus, in_halt_flag,
      input  out_pc_src, out_pc_branch, out_read_data, out_alu, out_write_reg,
             writeBack_bus_out, out_halt_flag, out_misaligned
   );

   modport slave (
      input  in_alu, in_reg2, in_write_reg, in_pc_branch, in_zero_flag,
             memory_bus, writeBack_bus, in_halt_flag,
      output out_pc_src, out_pc_branch, out_read_data, out_alu, out_write_reg,
             writeBack_bus_out, out_halt_flag, out_misaligned
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MIPS MEM stage + MEM/WB latch: 1-cycle latency, enable=0 stalls (hold, no store); branch decision combinational.
// Optional MEM_DEBUG_PORT_EN adds a combinational debug word-read port on the data RAM.
module mem_wb_stage #(
   parameter int len_data    = 32,
   parameter int num_bits    = 5,
   parameter int len_mem_bus = 9,
   parameter int len_wb_bus  = 2,
   parameter int ram_depth   = 256
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   mem_wb_stage_if.slave                bus
`ifdef MEM_DEBUG_PORT_EN
   ,
   input  logic [$clog2(ram_depth)-1:0] debug_addr,
   output logic [len_data-1:0]          debug_data
`endif
);
   localparam int AW = $clog2(ram_depth);

   logic [len_data-1:0] r_ram [ram_depth];

   logic [len_data-1:0]   r_read_data;
   logic [len_data-1:0]   r_alu;
   logic [num_bits-1:0]   r_write_reg;
   logic [len_wb_bus-1:0] r_wb;
   logic                  r_halt;
   logic                  r_misaligned;

   logic [AW-1:0]       w_idx;
   logic [1:0]          w_off;
   logic                w_rd, w_wr, w_uns, w_beq, w_bne;
   logic [1:0]          w_size;
   logic                w_misaligned;
   logic                w_do_store;
   logic [len_data-1:0] w_word;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [len_data-1:0] w_load;
   logic [3:0]          w_be;
   logic [len_data-1:0] w_wdata;
   logic                w_unused_bits;

   assign w_idx  = bus.in_alu[AW+1:2];
   assign w_off  = bus.in_alu[1:0];
   assign w_rd   = bus.memory_bus[0];
   assign w_wr   = bus.memory_bus[1];
   assign w_size = bus.memory_bus[3:2];
   assign w_uns  = bus.memory_bus[4];
   assign w_beq  = bus.memory_bus[5];
   assign w_bne  = bus.memory_bus[6];
   assign w_unused_bits = ^{bus.in_alu[len_data-1:AW+2], bus.memory_bus[len_mem_bus-1:7]};

   assign bus.out_pc_src    = (w_beq & bus.in_zero_flag) | (w_bne & ~bus.in_zero_flag);
   assign bus.out_pc_branch = bus.in_pc_branch;

   // Alignment only matters when the instruction actually touches memory.
   assign w_misaligned = (w_rd | w_wr) &
                         (((w_size == 2'b01) & w_off[0]) | (w_size[1] & (w_off != 2'b00)));
   assign w_do_store   = enable & reset & w_wr & ~w_misaligned;

   assign w_word = r_ram[w_idx];
   assign w_byte = w_word[8*w_off +: 8];
   assign w_half = w_word[16*w_off[1] +: 16];

   always_comb begin
      w_load  = w_word;
      w_be    = 4'b1111;
      w_wdata = bus.in_reg2;
      case (w_size)
         2'b00: begin
            w_load  = w_uns ? {{(len_data-8){1'b0}}, w_byte} : {{(len_data-8){w_byte[7]}}, w_byte};
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{bus.in_reg2[7:0]}};
         end
         2'b01: begin
            w_load  = w_uns ? {{(len_data-16){1'b0}}, w_half} : {{(len_data-16){w_half[15]}}, w_half};
            w_be    = w_off[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{bus.in_reg2[15:0]}};
         end
         default: begin
            w_load  = w_word;
            w_be    = 4'b1111;
            w_wdata = bus.in_reg2;
         end
      endcase
   end

   // RAM is never cleared; reads above see pre-write contents when read and write coincide.
   always_ff @(posedge clk) begin
      if (w_do_store) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_ram[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_read_data  <= '0;
         r_alu        <= '0;
         r_write_reg  <= '0;
         r_wb         <= '0;
         r_halt       <= 1'b0;
         r_misaligned <= 1'b0;
      end else if (enable) begin
         r_read_data  <= w_rd ? w_load : '0;
         r_alu        <= bus.in_alu;
         r_write_reg  <= bus.in_write_reg;
         r_wb         <= {bus.writeBack_bus[1] & ~w_misaligned, bus.writeBack_bus[0]};
         r_halt       <= bus.in_halt_flag;
         r_misaligned <= r_misaligned | w_misaligned;
      end
   end

   assign bus.out_read_data     = r_read_data;
   assign bus.out_alu           = r_alu;
   assign bus.out_write_reg     = r_write_reg;
   assign bus.writeBack_bus_out = r_wb;
   assign bus.out_halt_flag     = r_halt;
   assign bus.out_misaligned    = r_misaligned;

`ifdef MEM_DEBUG_PORT_EN
   assign debug_data = r_ram[debug_addr];
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: hand-computed loads/stores, branch decision, stall, reset, misalignment.
module tb_mem_wb_stage;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b1;
   int   tests = 0;
   int   failed = 0;

   always #5 clk = ~clk;

   mem_wb_stage_if #(.len_data(32), .num_bits(5), .len_mem_bus(9), .len_wb_bus(2)) bus ();

`ifdef MEM_DEBUG_PORT_EN
   logic [7:0]  debug_addr = '0;
   logic [31:0] debug_data;
`endif

   mem_wb_stage #(.len_data(32), .num_bits(5), .len_mem_bus(9), .len_wb_bus(2), .ram_depth(256)) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bus    (bus)
`ifdef MEM_DEBUG_PORT_EN
      ,
      .debug_addr (debug_addr),
      .debug_data (debug_data)
`endif
   );

   function automatic logic [8:0] mb(input bit rd, input bit wr, input logic [1:0] sz,
                                     input bit uns, input bit beq, input bit bne);
      return {2'b00, bne, beq, uns, sz, wr, rd};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] alu, input logic [31:0] reg2, input logic [8:0] m,
                        input logic [1:0] wb, input logic [4:0] wr);
      bus.in_alu        = alu;
      bus.in_reg2       = reg2;
      bus.memory_bus    = m;
      bus.writeBack_bus = wb;
      bus.in_write_reg  = wr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_pc_branch = 32'h0000_0400;
      bus.in_zero_flag = 1'b0;
      bus.in_halt_flag = 1'b1;
      // Reset with random inputs for two cycles
      for (int i = 0; i < 2; i++) begin
         drive($urandom, $urandom, 9'($urandom), 2'($urandom), 5'($urandom));
         tick();
      end
      check("rst_read_data", bus.out_read_data, 32'h0);
      check("rst_alu", bus.out_alu, 32'h0);
      check("rst_write_reg", 32'(bus.out_write_reg), 32'h0);
      check("rst_wb", 32'(bus.writeBack_bus_out), 32'h0);
      check("rst_halt", 32'(bus.out_halt_flag), 32'h0);
      check("rst_misaligned", 32'(bus.out_misaligned), 32'h0);

      reset = 1'b1;
      bus.in_halt_flag = 1'b0;
      drive(32'h10, 32'hDEADBEEF, mb(0, 1, 2'b10, 0, 0, 0), 2'b00, 5'd0);
      tick();
      check("st_word_alu", bus.out_alu, 32'h10);
      check("st_word_rdata_zero", bus.out_read_data, 32'h0);

      drive(32'h13, 32'h0, mb(1, 0, 2'b00, 0, 0, 0), 2'b11, 5'd7);
      tick();
      check("ld_byte_signed", bus.out_read_data, 32'hFFFFFFDE);
      check("ld_write_reg", 32'(bus.out_write_reg), 32'd7);
      check("ld_wb", 32'(bus.writeBack_bus_out), 32'h3);

      drive(32'h10, 32'h0, mb(1, 0, 2'b01, 1, 0, 0), 2'b11, 5'd8);
      tick();
      check("ld_half_unsigned", bus.out_read_data, 32'h0000BEEF);

      drive(32'h12, 32'h0, mb(1, 0, 2'b01, 0, 0, 0), 2'b11, 5'd8);
      tick();
      check("ld_half_signed_hi", bus.out_read_data, 32'hFFFFDEAD);

      drive(32'h13, 32'h0, mb(1, 0, 2'b00, 1, 0, 0), 2'b11, 5'd8);
      tick();
      check("ld_byte_unsigned", bus.out_read_data, 32'h000000DE);

      // Byte store followed immediately by word load (no bubble)
      drive(32'h11, 32'hFFFFFF5A, mb(0, 1, 2'b00, 0, 0, 0), 2'b00, 5'd0);
      tick();
      drive(32'h10, 32'h0, mb(1, 0, 2'b10, 0, 0, 0), 2'b11, 5'd9);
      tick();
      check("ld_after_byte_st", bus.out_read_data, 32'hDEAD5AEF);

      drive(32'h12, 32'hAAAA1234, mb(0, 1, 2'b01, 0, 0, 0), 2'b00, 5'd0);
      tick();
      drive(32'h10, 32'h0, mb(1, 0, 2'b11, 0, 0, 0), 2'b11, 5'd9);
      tick();
      check("ld_after_half_st_size11", bus.out_read_data, 32'h12345AEF);

      // Simultaneous read and write returns old data, then new
      drive(32'h10, 32'h01020304, mb(1, 1, 2'b10, 0, 0, 0), 2'b11, 5'd9);
      tick();
      check("rw_old_data", bus.out_read_data, 32'h12345AEF);
      drive(32'h410, 32'h0, mb(1, 0, 2'b10, 0, 0, 0), 2'b11, 5'd9);
      tick();
      check("rw_new_data_wrap", bus.out_read_data, 32'h01020304);

      // Misaligned word store
      drive(32'h20, 32'hAAAAAAAA, mb(0, 1, 2'b10, 0, 0, 0), 2'b00, 5'd0);
      tick();
      check("aligned_no_err", 32'(bus.out_misaligned), 32'h0);
      drive(32'h22, 32'h55555555, mb(0, 1, 2'b10, 0, 0, 0), 2'b11, 5'd3);
      tick();
      check("mis_wb_forced", 32'(bus.writeBack_bus_out), 32'h1);
      check("mis_flag_set", 32'(bus.out_misaligned), 32'h1);
      drive(32'h20, 32'h0, mb(1, 0, 2'b10, 0, 0, 0), 2'b11, 5'd3);
      tick();
      check("mis_ram_unchanged", bus.out_read_data, 32'hAAAAAAAA);
      check("mis_flag_sticky", 32'(bus.out_misaligned), 32'h1);
      check("aligned_wb_kept", 32'(bus.writeBack_bus_out), 32'h3);

      // Branch decision, combinational
      bus.in_pc_branch = 32'h0000_1234;
      bus.in_zero_flag = 1'b1;
      drive(32'h0, 32'h0, mb(0, 0, 2'b00, 0, 1, 0), 2'b00, 5'd0);
      #1 check("beq_zero1", 32'(bus.out_pc_src), 32'h1);
      check("pc_branch_pass", bus.out_pc_branch, 32'h1234);
      drive(32'h0, 32'h0, mb(0, 0, 2'b00, 0, 0, 1), 2'b00, 5'd0);
      #1 check("bne_zero1", 32'(bus.out_pc_src), 32'h0);
      bus.in_zero_flag = 1'b0;
      #1 check("bne_zero0", 32'(bus.out_pc_src), 32'h1);
      drive(32'h0, 32'h0, mb(0, 0, 2'b00, 0, 1, 0), 2'b00, 5'd0);
      #1 check("beq_zero0", 32'(bus.out_pc_src), 32'h0);
      tick();

      // Stall during store
      drive(32'h30, 32'h12121212, mb(0, 1, 2'b10, 0, 0, 0), 2'b10, 5'd4);
      tick();
      enable = 1'b0;
      bus.in_halt_flag = 1'b1;
      drive(32'h30, 32'h99999999, mb(1, 1, 2'b10, 0, 0, 0), 2'b11, 5'd17);
      tick();
      check("stall_alu_hold", bus.out_alu, 32'h30);
      check("stall_wreg_hold", 32'(bus.out_write_reg), 32'd4);
      check("stall_halt_hold", 32'(bus.out_halt_flag), 32'h0);
      enable = 1'b1;
      drive(32'h30, 32'h0, mb(1, 0, 2'b10, 0, 0, 0), 2'b11, 5'd4);
      tick();
      check("stall_no_store", bus.out_read_data, 32'h12121212);
      check("halt_reg", 32'(bus.out_halt_flag), 32'h1);
      bus.in_halt_flag = 1'b0;

      // Store suppressed under reset; reset clears sticky flag
      drive(32'h40, 32'h11111111, mb(0, 1, 2'b10, 0, 0, 0), 2'b00, 5'd0);
      tick();
      reset = 1'b0;
      drive(32'h40, 32'hCAFEF00D, mb(0, 1, 2'b10, 0, 0, 0), 2'b10, 5'd2);
      tick();
      check("rst2_misaligned", 32'(bus.out_misaligned), 32'h0);
      check("rst2_alu", bus.out_alu, 32'h0);
      reset = 1'b1;
      drive(32'h40, 32'h0, mb(1, 0, 2'b10, 0, 0, 0), 2'b11, 5'd2);
      tick();
      check("rst_store_suppressed", bus.out_read_data, 32'h11111111);

`ifdef MEM_DEBUG_PORT_EN
      drive(32'h14, 32'h12345678, mb(0, 1, 2'b10, 0, 0, 0), 2'b00, 5'd0);
      tick();
      debug_addr = 8'd5;
      #1 check("debug_read", debug_data, 32'h12345678);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
